baseball_solver_n: RTL

- Parametrised Number Baseball guesser: DIGITS positions, digits 0..RADIX-1, all digits of the secret distinct.
- Generates questions using a consistent-candidate search and stops when the grader confirms the secret.
- Each question is the lexicographically smallest distinct-digit candidate that agrees with every stored (guess, strike, ball) record.
- Connects to the grader over independent valid/ready ask and reply channels; a new run is triggered by start.

---
 rtl/baseball_solver_n.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/baseball_solver_n.sv
// Number Baseball guesser: proposes the smallest distinct-digit candidate that is
// consistent with every (guess, strike, ball) reply seen so far in this run.
module baseball_solver_n #(
  parameter int DIGITS     = 4,
  parameter int RADIX      = 10,
  parameter int HIST_DEPTH = 16,
  localparam int CW        = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [4*DIGITS-1:0] question,
  output logic                ask_valid,
  input  logic                ask_ready,
  input  logic                reply_valid,
  output logic                reply_ready,
  input  logic [CW-1:0]       strike,
  input  logic [CW-1:0]       ball,
  input  logic                correct,
  output logic                done,
  output logic                fail,
  output logic [7:0]          guess_count
);

  localparam int QW     = 4 * DIGITS;
  localparam int HCW    = $clog2(HIST_DEPTH + 1);
  localparam int IW     = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int HSLOTS = 1 << IW;
  localparam int EW     = QW + 2 * CW;
  localparam logic [4:0] RADIX_W = 5'(RADIX);

  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_ASK, S_WAIT, S_DONE, S_FAIL} state_t;

  function automatic logic [QW-1:0] first_cand();
    logic [QW-1:0] c;
    c = '0;
    for (int p = 0; p < DIGITS; p++) c[4*(DIGITS-1-p) +: 4] = 4'(p);
    return c;
  endfunction

  function automatic logic cand_ok(input logic [QW-1:0] c);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ({1'b0, c[4*i +: 4]} >= RADIX_W) ok = 1'b0;
      for (int j = i + 1; j < DIGITS; j++)
        if (c[4*i +: 4] == c[4*j +: 4]) ok = 1'b0;
    end
    return ok;
  endfunction

  // Odometer step with nibble 0 (last position) least significant; MSB of result is carry out.
  function automatic logic [QW:0] advance(input logic [QW-1:0] c);
    logic [QW-1:0] n;
    logic          carry;
    n     = c;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if ({1'b0, n[4*i +: 4]} == RADIX_W - 5'd1) begin
          n[4*i +: 4] = 4'd0;
        end else begin
          n[4*i +: 4] = n[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return {carry, n};
  endfunction

  function automatic logic [2*CW-1:0] score(input logic [QW-1:0] a, input logic [QW-1:0] b);
    logic [CW-1:0] s;
    logic [CW-1:0] bl;
    s  = '0;
    bl = '0;
    for (int i = 0; i < DIGITS; i++)
      for (int j = 0; j < DIGITS; j++)
        if (a[4*i +: 4] == b[4*j +: 4]) begin
          if (i == j) s = s + CW'(1);
          else bl = bl + CW'(1);
        end
    return {s, bl};
  endfunction

  state_t          state_q, state_d;
  logic [QW-1:0]   cand_q, cand_d;
  logic [HCW-1:0]  h_q, h_d;
  logic [HCW-1:0]  hist_cnt_q, hist_cnt_d;
  logic [QW-1:0]   question_q, question_d;
  logic [7:0]      guess_count_q, guess_count_d;
  logic            ask_valid_q, ask_valid_d;
  logic            reply_ready_q, reply_ready_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;

  logic [EW-1:0]   hist_q [HSLOTS];
  logic            hist_we;
  logic [EW-1:0]   hist_wdata;
  logic [EW-1:0]   hist_rd;
  logic [QW:0]     adv;
  logic [2*CW-1:0] cand_score;
  logic            mismatch;

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    h_d           = h_q;
    hist_cnt_d    = hist_cnt_q;
    question_d    = question_q;
    guess_count_d = guess_count_q;
    hist_we       = 1'b0;
    hist_wdata    = {question_q, strike, ball};
    hist_rd       = hist_q[h_q[IW-1:0]];
    adv           = advance(cand_q);
    cand_score    = score(cand_q, hist_rd[EW-1 -: QW]);
    mismatch      = (h_q < hist_cnt_q) && (cand_score != hist_rd[2*CW-1:0]);

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d       = S_SEARCH;
          cand_d        = first_cand();
          h_d           = '0;
          hist_cnt_d    = '0;
          guess_count_d = '0;
        end
      end
      S_SEARCH: begin
        if (!cand_ok(cand_q) || mismatch) begin
          if (adv[QW]) begin
            state_d = S_FAIL;
          end else begin
            cand_d = adv[QW-1:0];
            h_d    = '0;
          end
        end else if (h_q < hist_cnt_q) begin
          h_d = h_q + HCW'(1);
        end else begin
          question_d = cand_q;
          state_d    = S_ASK;
        end
      end
      S_ASK: begin
        if (ask_ready) begin
          guess_count_d = (guess_count_q == 8'hFF) ? guess_count_q : guess_count_q + 8'd1;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (reply_valid) begin
          if (correct || strike == CW'(DIGITS)) begin
            state_d = S_DONE;
          end else if (hist_cnt_q == HCW'(HIST_DEPTH)) begin
            state_d = S_FAIL;
          end else begin
            hist_we    = 1'b1;
            hist_cnt_d = hist_cnt_q + HCW'(1);
            h_d        = '0;
            if (adv[QW]) begin
              state_d = S_FAIL;
            end else begin
              cand_d  = adv[QW-1:0];
              state_d = S_SEARCH;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ask_valid_d   = (state_d == S_ASK);
    reply_ready_d = (state_d == S_WAIT);
    done_d        = (state_d == S_DONE);
    fail_d        = (state_d == S_FAIL);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cand_q        <= '0;
      h_q           <= '0;
      hist_cnt_q    <= '0;
      question_q    <= '0;
      guess_count_q <= '0;
      ask_valid_q   <= 1'b0;
      reply_ready_q <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      h_q           <= h_d;
      hist_cnt_q    <= hist_cnt_d;
      question_q    <= question_d;
      guess_count_q <= guess_count_d;
      ask_valid_q   <= ask_valid_d;
      reply_ready_q <= reply_ready_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
    end
  end

  // History needs no reset: hist_cnt_q gates which entries are ever read.
  always_ff @(posedge clk) begin
    if (hist_we) hist_q[hist_cnt_q[IW-1:0]] <= hist_wdata;
  end

  assign question    = question_q;
  assign ask_valid   = ask_valid_q;
  assign reply_ready = reply_ready_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign guess_count = guess_count_q;

endmodule
